mips_mc_ctrl: RTL and testbench

Multicycle control unit for the MIPS core. It sequences the shared 32-bit ALU (codes AND=000, OR=001, ADD=010, EQ=100, SLT=111), memory, IR, register file and PC through per-instruction state sequences. It drives the ALU operation code and all datapath mux selects and write enables, and stalls on a memory ready handshake. It sits between the instruction register and the datapath top.

---
 rtl/mips_ctrl_pkg.sv | 66 ++++++
 rtl/mips_mc_ctrl_alu_dec.sv | 31 +++
 rtl/mips_mc_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcode/funct constants, ALU operation codes and datapath select values.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Controller states; the numeric values are visible on state_o for debug
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_EQ  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B operand select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the controller knows how to sequence
  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_is_legal = 1'b1;
      default:                                       op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_alu_dec.sv
// ---------------------------------------------------------------------------
// alu_dec
// Combinational R-type funct decoder.
// Ports:
//   funct   in   OPW  R-type funct field
//   alucont out  3    ALU operation code (ADD when funct is not recognised)
//   valid   out  1    funct is one of the supported R-type operations
// ---------------------------------------------------------------------------
module alu_dec
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] funct,
  output logic [2:0]     alucont,
  output logic           valid
);

  always_comb begin
    alucont = ALU_ADD;
    valid   = 1'b1;
    case (funct)
      FN_ADD:  alucont = ALU_ADD;
      FN_AND:  alucont = ALU_AND;
      FN_OR:   alucont = ALU_OR;
      FN_SLT:  alucont = ALU_SLT;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// mips_mc_ctrl
// Multicycle MIPS control unit. Walks each instruction through its state
// sequence and decodes the datapath controls from the current state.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   op, funct         IR[31:26] and IR[5:0]
//   alu_eq            ALU result bit 0, used for beq
//   mem_ready         memory finishes its access this cycle
//   memread/memwrite  memory strobes
//   irwrite/regwrite  IR load and register file write
//   iord, memtoreg, regdst, alusrca, alusrcb, pcsrc   datapath selects
//   pcen              PC write enable
//   alucont           ALU operation code
//   illegal_op        pulse on an undecodable op or funct
//   state_o           current state for debug
// ---------------------------------------------------------------------------
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] op,
  input  logic [OPW-1:0] funct,
  input  logic           alu_eq,
  input  logic           mem_ready,
  output logic           memread,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regwrite,
  output logic           iord,
  output logic           memtoreg,
  output logic           regdst,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic           pcen,
  output logic [2:0]     alucont,
  output logic           illegal_op,
  output logic [3:0]     state_o
);

  state_t         r_state;
  logic [OPW-1:0] r_funct;
  logic [2:0]     w_rtype_alucont;
  logic           w_rtype_valid;

  // funct is captured in DECODE so the R-type execute and write-back steps
  // see the same operation even if the IR changes underneath.
  alu_dec #(.OPW(OPW)) u_alu_dec (
    .funct   (r_funct),
    .alucont (w_rtype_alucont),
    .valid   (w_rtype_valid)
  );

  // State register and next-state sequencing. Memory states wait for
  // mem_ready; undecodable op/funct return straight to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_funct <= '0;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_funct <= funct;
          case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_RTYPEEX;
            OP_BEQ:       r_state <= S_BEQEX;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JEX;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:  r_state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:   r_state <= S_FETCH;
        S_MEMWR:   if (mem_ready) r_state <= S_FETCH;
        S_RTYPEEX: r_state <= w_rtype_valid ? S_RTYPEWB : S_FETCH;
        S_RTYPEWB: r_state <= S_FETCH;
        S_BEQEX:   r_state <= S_FETCH;
        S_ADDIEX:  r_state <= S_ADDIWB;
        S_ADDIWB:  r_state <= S_FETCH;
        S_JEX:     r_state <= S_FETCH;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode straight from the state register so that an async reset
  // kills every strobe (no partial writes) in the same cycle. Only FETCH
  // (mem_ready), BEQEX (alu_eq), DECODE (op) and the R-type states (funct)
  // look at inputs.
  always_comb begin
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REGB;
    pcsrc      = PCSRC_ALU;
    pcen       = 1'b0;
    alucont    = ALU_ADD;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        memread = 1'b1;
        irwrite = mem_ready;
        alusrcb = SRCB_FOUR;
        pcen    = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMMSH;
        illegal_op = ~op_is_legal(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucont    = w_rtype_alucont;
        illegal_op = ~w_rtype_valid;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        alucont  = w_rtype_alucont;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        alucont = ALU_EQ;
        pcsrc   = PCSRC_ALUOUT;
        pcen    = alu_eq;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc = PCSRC_JUMP;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_mc_ctrl
// Scoreboard bench for the multicycle controller. The stimulus process drives
// one cycle of inputs at a time and queues the state and output vector that
// cycle should show; the monitor pops and compares mid-cycle.
// ---------------------------------------------------------------------------
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       alu_eq = 1'b0;
  logic       mem_ready = 1'b1;
  logic       memread, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, illegal_op;
  logic [2:0] alucont;
  logic [3:0] state_o;

  typedef struct {
    string      name;
    logic [3:0] st;
    logic [16:0] outs;
  } expEntry_t;

  expEntry_t expQueue[$];
  int errorCount = 0;
  int checkCount = 0;

  mips_mc_ctrl #(.OPW(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .alu_eq     (alu_eq),
    .mem_ready  (mem_ready),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucont    (alucont),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Reference output vector for a state, packed as
  // {memread,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,
  //  alusrcb,pcsrc,pcen,alucont,illegal_op}
  function automatic logic [16:0] expectedOutputs(input logic [3:0] st, input logic [5:0] opIn,
                                                  input logic [5:0] fnIn, input logic eqIn,
                                                  input logic readyIn);
    logic mr, mw, ir, rw, io, m2r, rd, sa, pe, il;
    logic [1:0] sb, ps;
    logic [2:0] ac, fnCode;
    logic fnOk;
    {mr, mw, ir, rw, io, m2r, rd, sa, pe, il} = '0;
    sb = 2'b00;
    ps = 2'b00;
    ac = 3'b010;
    fnOk = 1'b1;
    fnCode = 3'b010;
    case (fnIn)
      6'b100000: fnCode = 3'b010;
      6'b100100: fnCode = 3'b000;
      6'b100101: fnCode = 3'b001;
      6'b101010: fnCode = 3'b111;
      default:   fnOk = 1'b0;
    endcase
    case (st)
      4'd1:  begin mr = 1'b1; ir = readyIn; pe = readyIn; sb = 2'b01; end
      4'd2:  begin
               sb = 2'b11;
               il = !(opIn inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
             end
      4'd3:  begin sa = 1'b1; sb = 2'b10; end
      4'd4:  begin mr = 1'b1; io = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin mw = 1'b1; io = 1'b1; end
      4'd7:  begin sa = 1'b1; ac = fnCode; il = !fnOk; end
      4'd8:  begin rw = 1'b1; rd = 1'b1; ac = fnCode; end
      4'd9:  begin sa = 1'b1; ac = 3'b100; ps = 2'b01; pe = eqIn; end
      4'd10: begin sa = 1'b1; sb = 2'b10; end
      4'd11: rw = 1'b1;
      4'd12: begin ps = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    return {mr, mw, ir, rw, io, m2r, rd, sa, sb, ps, pe, ac, il};
  endfunction

  // Drive one cycle of inputs and queue the hand-picked state for that cycle
  task automatic applyStimulus(input string name, input logic rstIn, input logic [5:0] opIn,
                               input logic [5:0] fnIn, input logic eqIn, input logic readyIn,
                               input logic [3:0] expState);
    expEntry_t e;
    @(posedge clk);
    #1;
    rst_n = rstIn;
    op = opIn;
    funct = fnIn;
    alu_eq = eqIn;
    mem_ready = readyIn;
    e.name = name;
    e.st = expState;
    e.outs = expectedOutputs(expState, opIn, fnIn, eqIn, readyIn);
    expQueue.push_back(e);
  endtask

  // Compare the live DUT against one queued expectation
  task automatic checkOutput(input expEntry_t e);
    logic [16:0] got;
    got = {memread, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
           alusrcb, pcsrc, pcen, alucont, illegal_op};
    checkCount++;
    if (state_o !== e.st) begin
      errorCount++;
      $display("[TB] FAIL %s state: got %0d expected %0d", e.name, state_o, e.st);
    end
    checkCount++;
    if (got !== e.outs) begin
      errorCount++;
      $display("[TB] FAIL %s outputs: got %b expected %b", e.name, got, e.outs);
    end
  endtask

  // Monitor: every cycle's outputs are presented mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (expQueue.size() > 0) checkOutput(expQueue.pop_front());
    end
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  // Walk an instruction with no stalls through its expected state list
  task automatic runInstr(input string name, input logic [5:0] opIn, input logic [5:0] fnIn,
                          input logic eqIn, input logic [3:0] states[$]);
    foreach (states[i]) applyStimulus(name, 1'b1, opIn, fnIn, eqIn, 1'b1, states[i]);
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus("reset", 1'b0, RT, 6'd0, 1'b0, 1'b1, 4'd0);
    applyStimulus("reset", 1'b0, RT, 6'd0, 1'b0, 1'b1, 4'd0);
    applyStimulus("release", 1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd0);

    runInstr("lw", LW, 6'd0, 1'b0, '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5});

    // lw with three stall cycles in MEMRD: 8 cycles total
    runInstr("lwStall", LW, 6'd0, 1'b0, '{4'd1, 4'd2, 4'd3});
    repeat (3) applyStimulus("lwStallRd", 1'b1, LW, 6'd0, 1'b0, 1'b0, 4'd4);
    runInstr("lwStall", LW, 6'd0, 1'b0, '{4'd4, 4'd5});

    runInstr("slt", RT, 6'b101010, 1'b0, '{4'd1, 4'd2, 4'd7, 4'd8});
    runInstr("or", RT, 6'b100101, 1'b0, '{4'd1, 4'd2, 4'd7, 4'd8});
    runInstr("and", RT, 6'b100100, 1'b0, '{4'd1, 4'd2, 4'd7, 4'd8});
    runInstr("badFunct", RT, 6'b000011, 1'b0, '{4'd1, 4'd2, 4'd7});

    runInstr("beqTaken", BEQ, 6'd0, 1'b1, '{4'd1, 4'd2, 4'd9});
    runInstr("beqNot", BEQ, 6'd0, 1'b0, '{4'd1, 4'd2, 4'd9});
    runInstr("addi", ADDI, 6'd0, 1'b0, '{4'd1, 4'd2, 4'd10, 4'd11});
    runInstr("j", JMP, 6'd0, 1'b0, '{4'd1, 4'd2, 4'd12});
    runInstr("sw", SW, 6'd0, 1'b0, '{4'd1, 4'd2, 4'd3, 4'd6});

    // Fetch stall, then sw interrupted by reset while stalled in MEMWR
    applyStimulus("fetchStall", 1'b1, SW, 6'd0, 1'b0, 1'b0, 4'd1);
    runInstr("swRst", SW, 6'd0, 1'b0, '{4'd1, 4'd2, 4'd3});
    applyStimulus("swRstWr", 1'b1, SW, 6'd0, 1'b0, 1'b0, 4'd6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (memwrite !== 1'b0 || regwrite !== 1'b0 || state_o !== 4'd0) begin
      errorCount++;
      $display("[TB] FAIL asyncReset: got memwrite=%b regwrite=%b state=%0d expected 0 0 0",
               memwrite, regwrite, state_o);
    end
    applyStimulus("midReset", 1'b0, 6'b111111, 6'd0, 1'b0, 1'b0, 4'd0);
    applyStimulus("midRelease", 1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, 4'd0);
    runInstr("badOp", 6'b111111, 6'd0, 1'b0, '{4'd1, 4'd2, 4'd1});

    // Let the monitor drain, bounded
    for (int i = 0; i < 20 && expQueue.size() > 0; i++) @(negedge clk);
    if (expQueue.size() > 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQueue.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
